// File: rtl/hazard_unit.sv
// Hazard detection, operand forwarding selects, stall/flush generation and
// multi-cycle divide sequencing for the 5-stage MIPS pipeline.
module hazard_unit #(
   parameter int unsigned DIV_CYCLES = 32
) (
   input  logic        clk,
   input  logic        rst,
   input  logic [4:0]  rsD,
   input  logic [4:0]  rtD,
   input  logic [4:0]  rsE,
   input  logic [4:0]  rtE,
   input  logic [4:0]  writeregE,
   input  logic [4:0]  writeregM,
   input  logic [4:0]  writeregW,
   input  logic        regwriteE,
   input  logic        regwriteM,
   input  logic        regwriteW,
   input  logic        memtoregE,
   input  logic        memtoregM,
   input  logic        branchD,
   input  logic        jrD,
   input  logic        divE,
   input  logic        i_stall,
   input  logic        d_stall,
   input  logic [31:0] excepttypeM,
   output logic        forwardAD,
   output logic        forwardBD,
   output logic [1:0]  forwardAE,
   output logic [1:0]  forwardBE,
   output logic        stallF,
   output logic        stallD,
   output logic        stallE,
   output logic        stallM,
   output logic        stallW,
   output logic        flushD,
   output logic        flushE,
   output logic        flushM,
   output logic        flushW,
   output logic        div_start,
   output logic        div_done
);

   localparam int unsigned      CW       = $clog2(DIV_CYCLES);
   localparam logic [CW-1:0]    CNT_LOAD = CW'(DIV_CYCLES - 1);
   localparam logic [CW-1:0]    CNT_LAST = CW'(1);

   typedef enum logic [1:0] {
      DIV_IDLE = 2'd0,
      DIV_BUSY = 2'd1,
      DIV_DONE = 2'd2
   } div_state_e;

   div_state_e    r_div_state;
   div_state_e    w_div_state_nxt;
   logic [CW-1:0] r_div_cnt;
   logic [CW-1:0] w_div_cnt_nxt;

   logic w_memstall;
   logic w_except;
   logic w_lwstall;
   logic w_branchstall;
   logic w_divstall;
   logic w_div_go;
   logic w_front_stall;

   // $0 is hardwired, so a write to it never produces a dependence.
   function automatic logic src_hit(input logic       en,
                                    input logic [4:0] dst,
                                    input logic [4:0] src);
      return en && (dst != 5'd0) && (dst == src);
   endfunction

   // ---------------- forwarding ----------------
   assign forwardAE = src_hit(regwriteM, writeregM, rsE) ? 2'b10 :
                      src_hit(regwriteW, writeregW, rsE) ? 2'b01 : 2'b00;
   assign forwardBE = src_hit(regwriteM, writeregM, rtE) ? 2'b10 :
                      src_hit(regwriteW, writeregW, rtE) ? 2'b01 : 2'b00;
   assign forwardAD = src_hit(regwriteM, writeregM, rsD);
   assign forwardBD = src_hit(regwriteM, writeregM, rtD);

   // ---------------- hazard sources ----------------
   assign w_memstall = i_stall | d_stall;
   assign w_except   = (excepttypeM != 32'd0) & ~w_memstall;

   assign w_lwstall  = src_hit(memtoregE, writeregE, rsD) |
                       src_hit(memtoregE, writeregE, rtD);

   // Branch operands are compared in D, so an ALU result still in E or a
   // load still in M cannot be forwarded in time.
   assign w_branchstall = (branchD | jrD) &
                          (src_hit(regwriteE, writeregE, rsD) |
                           src_hit(regwriteE, writeregE, rtD) |
                           src_hit(memtoregM, writeregM, rsD) |
                           src_hit(memtoregM, writeregM, rtD));

   assign w_divstall = ((r_div_state == DIV_IDLE) & divE & ~w_except) |
                       (r_div_state == DIV_BUSY);

   // ---------------- divide sequencer ----------------
   // NOTE: every signal written here gets a default first so no path leaves
   // it unassigned; otherwise synthesis infers a latch.
   always_comb begin
      w_div_state_nxt = r_div_state;
      w_div_cnt_nxt   = r_div_cnt;
      w_div_go        = 1'b0;
      case (r_div_state)
         DIV_IDLE: begin
            if (divE && !w_memstall && !w_except) begin
               w_div_state_nxt = DIV_BUSY;
               w_div_cnt_nxt   = CNT_LOAD;
               w_div_go        = 1'b1;
            end
         end
         DIV_BUSY: begin
            // The countdown keeps running under memstall; only an exception
            // abandons the divide.
            if (w_except) begin
               w_div_state_nxt = DIV_IDLE;
               w_div_cnt_nxt   = '0;
            end else begin
               w_div_cnt_nxt = r_div_cnt - CNT_LAST;
               if (r_div_cnt == CNT_LAST) w_div_state_nxt = DIV_DONE;
            end
         end
         DIV_DONE: begin
            if (!w_memstall) w_div_state_nxt = DIV_IDLE;
         end
         default: begin
            w_div_state_nxt = DIV_IDLE;
            w_div_cnt_nxt   = '0;
         end
      endcase
   end

   // NOTE: sequential state uses non-blocking assignments so every register
   // samples pre-edge values regardless of statement order.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_div_state <= DIV_IDLE;
         r_div_cnt   <= '0;
      end else begin
         r_div_state <= w_div_state_nxt;
         r_div_cnt   <= w_div_cnt_nxt;
      end
   end

   // The start pulse is decoded from IDLE, so it is masked while reset is held.
   assign div_start = w_div_go & ~rst;
   assign div_done  = (r_div_state == DIV_DONE);

   // ---------------- stalls and flushes ----------------
   assign w_front_stall = w_lwstall | w_branchstall | w_divstall | w_memstall;

   assign stallF = w_front_stall & ~w_except;
   assign stallD = w_front_stall & ~w_except;
   assign stallE = (w_divstall | w_memstall) & ~w_except;
   assign stallM = w_memstall & ~w_except;
   assign stallW = w_memstall & ~w_except;

   assign flushD = w_except;
   assign flushE = ((w_lwstall | w_branchstall) & ~w_divstall & ~w_memstall) | w_except;
   assign flushM = (w_divstall & ~w_memstall) | w_except;
   assign flushW = 1'b0;

endmodule

// File: tb/tb_hazard_unit.sv
// Self-checking bench for hazard_unit: directed scenarios plus randomized
// stimulus compared against a cycle-count reference model.
module tb_hazard_unit;

   localparam int N = 32;

   logic        clk = 1'b0;
   logic        rst;
   logic [4:0]  rsD, rtD, rsE, rtE, writeregE, writeregM, writeregW;
   logic        regwriteE, regwriteM, regwriteW, memtoregE, memtoregM;
   logic        branchD, jrD, divE, i_stall, d_stall;
   logic [31:0] excepttypeM;
   logic        forwardAD, forwardBD;
   logic [1:0]  forwardAE, forwardBE;
   logic        stallF, stallD, stallE, stallM, stallW;
   logic        flushD, flushE, flushM, flushW;
   logic        div_start, div_done;

   typedef struct packed {
      logic       fad, fbd;
      logic [1:0] fae, fbe;
      logic       sf, sd, se, sm, sw;
      logic       fd, fe, fm, fw;
      logic       ds, dd;
   } outs_t;

   int n_checks = 0;
   int n_fail   = 0;
   // Reference divide model: cycles elapsed since the start cycle (0 = no divide).
   int m_elapsed = 0;

   hazard_unit #(.DIV_CYCLES(N)) dut (
      .clk(clk), .rst(rst),
      .rsD(rsD), .rtD(rtD), .rsE(rsE), .rtE(rtE),
      .writeregE(writeregE), .writeregM(writeregM), .writeregW(writeregW),
      .regwriteE(regwriteE), .regwriteM(regwriteM), .regwriteW(regwriteW),
      .memtoregE(memtoregE), .memtoregM(memtoregM),
      .branchD(branchD), .jrD(jrD), .divE(divE),
      .i_stall(i_stall), .d_stall(d_stall), .excepttypeM(excepttypeM),
      .forwardAD(forwardAD), .forwardBD(forwardBD),
      .forwardAE(forwardAE), .forwardBE(forwardBE),
      .stallF(stallF), .stallD(stallD), .stallE(stallE), .stallM(stallM), .stallW(stallW),
      .flushD(flushD), .flushE(flushE), .flushM(flushM), .flushW(flushW),
      .div_start(div_start), .div_done(div_done)
   );

   always #5 clk = ~clk;

   function automatic outs_t dut_outs();
      outs_t o;
      o = '{forwardAD, forwardBD, forwardAE, forwardBE,
            stallF, stallD, stallE, stallM, stallW,
            flushD, flushE, flushM, flushW, div_start, div_done};
      return o;
   endfunction

   function automatic logic [1:0] ref_fwd(input logic [4:0] src);
      if (regwriteM && writeregM != 0 && writeregM == src) return 2'b10;
      if (regwriteW && writeregW != 0 && writeregW == src) return 2'b01;
      return 2'b00;
   endfunction

   function automatic outs_t model_outputs();
      outs_t o;
      bit mem, exc, lw, br, dv, idle, busy, done;
      mem  = i_stall || d_stall;
      exc  = (excepttypeM != 0) && !mem;
      lw   = memtoregE && writeregE != 0 && (writeregE == rsD || writeregE == rtD);
      br   = (branchD || jrD) &&
             ((regwriteE && writeregE != 0 && (writeregE == rsD || writeregE == rtD)) ||
              (memtoregM && writeregM != 0 && (writeregM == rsD || writeregM == rtD)));
      idle = (m_elapsed == 0);
      busy = (m_elapsed > 0) && (m_elapsed < N);
      done = (m_elapsed == N);
      dv   = (idle && divE && !exc) || busy;
      o.fad = regwriteM && writeregM != 0 && writeregM == rsD;
      o.fbd = regwriteM && writeregM != 0 && writeregM == rtD;
      o.fae = ref_fwd(rsE);
      o.fbe = ref_fwd(rtE);
      o.sf  = !exc && (lw || br || dv || mem);
      o.sd  = o.sf;
      o.se  = !exc && (dv || mem);
      o.sm  = !exc && mem;
      o.sw  = o.sm;
      o.fd  = exc;
      o.fe  = ((lw || br) && !dv && !mem) || exc;
      o.fm  = (dv && !mem) || exc;
      o.fw  = 1'b0;
      o.ds  = idle && divE && !mem && !exc && !rst;
      o.dd  = done;
      return o;
   endfunction

   task automatic model_step();
      bit mem, exc;
      mem = i_stall || d_stall;
      exc = (excepttypeM != 0) && !mem;
      if (rst)                 m_elapsed = 0;
      else if (m_elapsed == 0) begin if (divE && !mem && !exc) m_elapsed = 1; end
      else if (m_elapsed < N)  m_elapsed = exc ? 0 : m_elapsed + 1;
      else if (!mem)           m_elapsed = 0;
   endtask

   task automatic tick();
      @(posedge clk);
      model_step();
      #1;
   endtask

   task automatic idle_inputs();
      {rsD, rtD, rsE, rtE, writeregE, writeregM, writeregW} = '0;
      {regwriteE, regwriteM, regwriteW, memtoregE, memtoregM} = '0;
      {branchD, jrD, divE, i_stall, d_stall} = '0;
      excepttypeM = '0;
   endtask

   task automatic test_reset();
      outs_t got;
      rst = 1'b1;
      idle_inputs();
      tick(); tick();
      @(negedge clk);
      got = dut_outs();
      n_checks++;
      if (got !== outs_t'(0)) begin
         n_fail++; $display("FAIL reset_outputs: got %h want %h", got, outs_t'(0));
      end
      divE = 1'b1;
      #1;
      n_checks++;
      if (div_start !== 1'b0 || div_done !== 1'b0) begin
         n_fail++; $display("FAIL reset_div_start: got %b%b want 00", div_start, div_done);
      end
      divE = 1'b0;
      tick();
      rst = 1'b0;
      tick();
      @(negedge clk);
      got = dut_outs();
      n_checks++;
      if (got !== outs_t'(0) || got !== model_outputs()) begin
         n_fail++; $display("FAIL idle_outputs: got %h want %h", got, outs_t'(0));
      end
      tick();
   endtask

   task automatic test_lwstall();
      outs_t got, exp;
      idle_inputs();
      for (int c = 0; c < 3; c++) begin
         case (c)
            0: begin memtoregE = 1; regwriteE = 1; writeregE = 5'd2; rsD = 5'd2; rtD = 5'd7; end
            1: begin {memtoregE, regwriteE, writeregE} = '0; memtoregM = 1; regwriteM = 1; writeregM = 5'd2; end
            default: begin {memtoregM, regwriteM, writeregM} = '0; regwriteW = 1; writeregW = 5'd2;
                           rsE = 5'd2; rsD = 5'd9; end
         endcase
         @(negedge clk);
         exp = model_outputs(); got = dut_outs();
         n_checks++;
         if (got !== exp) begin
            n_fail++; $display("FAIL lwstall_model c%0d: got %h want %h", c, got, exp);
         end
         n_checks++;
         if (c == 0 && {stallF, stallD, flushE, stallE} !== 4'b1110) begin
            n_fail++; $display("FAIL lwstall_bubble: got %b want 1110", {stallF, stallD, flushE, stallE});
         end else if (c == 1 && {stallF, flushE} !== 2'b00) begin
            n_fail++; $display("FAIL lwstall_once: got %b want 00", {stallF, flushE});
         end else if (c == 2 && forwardAE !== 2'b01) begin
            n_fail++; $display("FAIL lw_fwd_w: got %b want 01", forwardAE);
         end
         tick();
      end
   endtask

   task automatic test_branch_and_zero();
      outs_t got, exp;
      for (int c = 0; c < 3; c++) begin
         idle_inputs();
         case (c)
            0: begin regwriteM = 1; writeregM = 5'd3; rsD = 5'd3; branchD = 1; end
            1: begin regwriteE = 1; writeregE = 5'd3; rtD = 5'd3; branchD = 1; end
            default: begin regwriteM = 1; regwriteW = 1; memtoregE = 1; end
         endcase
         @(negedge clk);
         exp = model_outputs(); got = dut_outs();
         n_checks++;
         if (got !== exp) begin
            n_fail++; $display("FAIL branch_model c%0d: got %h want %h", c, got, exp);
         end
         n_checks++;
         if (c == 0 && {forwardAD, stallF, flushE} !== 3'b100) begin
            n_fail++; $display("FAIL branch_fwd: got %b want 100", {forwardAD, stallF, flushE});
         end else if (c == 1 && {stallF, stallD, flushE} !== 3'b111) begin
            n_fail++; $display("FAIL branchstall: got %b want 111", {stallF, stallD, flushE});
         end else if (c == 2 && {forwardAE, stallF, flushE} !== 4'b0000) begin
            n_fail++; $display("FAIL reg0_hazard: got %b want 0000", {forwardAE, stallF, flushE});
         end
         tick();
      end
   endtask

   task automatic test_div();
      outs_t got, exp;
      int se_cycles = 0;
      idle_inputs();
      divE = 1'b1;
      for (int c = 0; c <= N + 1; c++) begin
         if (c == N + 1) divE = 1'b0;
         @(negedge clk);
         exp = model_outputs(); got = dut_outs();
         n_checks++;
         if (got !== exp) begin
            n_fail++; $display("FAIL div_model c%0d: got %h want %h", c, got, exp);
         end
         if (stallE) se_cycles++;
         n_checks++;
         if (div_start !== (c == 0) || div_done !== (c == N) ||
             stallE !== (c < N) || flushM !== (c < N)) begin
            n_fail++; $display("FAIL div_timing c%0d: got start=%b done=%b stallE=%b flushM=%b",
                               c, div_start, div_done, stallE, flushM);
         end
         tick();
      end
      n_checks++;
      if (se_cycles != N) begin
         n_fail++; $display("FAIL div_stall_len: got %0d want %0d", se_cycles, N);
      end
   endtask

   task automatic test_div_done_hold();
      outs_t got, exp;
      idle_inputs();
      divE = 1'b1;
      for (int c = 0; c < N + 4; c++) begin
         i_stall = (c == N || c == N + 1);
         @(negedge clk);
         exp = model_outputs(); got = dut_outs();
         n_checks++;
         if (got !== exp) begin
            n_fail++; $display("FAIL done_hold_model c%0d: got %h want %h", c, got, exp);
         end
         if (c >= N && c <= N + 2) begin
            n_checks++;
            if (div_done !== 1'b1 || div_start !== 1'b0) begin
               n_fail++; $display("FAIL done_hold c%0d: got done=%b start=%b want 1 0", c, div_done, div_start);
            end
         end
         tick();
      end
      idle_inputs();
      tick();
   endtask

   task automatic test_memstall_except();
      outs_t got, exp;
      idle_inputs();
      excepttypeM = 32'h4;
      for (int c = 0; c < 4; c++) begin
         d_stall = (c < 3);
         @(negedge clk);
         exp = model_outputs(); got = dut_outs();
         n_checks++;
         if (got !== exp) begin
            n_fail++; $display("FAIL memexc_model c%0d: got %h want %h", c, got, exp);
         end
         n_checks++;
         if (c < 3 && {stallF, stallD, stallE, stallM, stallW, flushD, flushE, flushM, flushW} !== 9'b111110000) begin
            n_fail++; $display("FAIL memstall_hold c%0d: got %b want 111110000", c,
                               {stallF, stallD, stallE, stallM, stallW, flushD, flushE, flushM, flushW});
         end else if (c == 3 && {stallF, stallD, stallE, stallM, stallW, flushD, flushE, flushM, flushW} !== 9'b000001110) begin
            n_fail++; $display("FAIL except_flush: got %b want 000001110",
                               {stallF, stallD, stallE, stallM, stallW, flushD, flushE, flushM, flushW});
         end
         tick();
      end
      idle_inputs();
   endtask

   task automatic test_div_except();
      outs_t got, exp;
      int done_seen = 0;
      idle_inputs();
      divE = 1'b1;
      for (int c = 0; c < N + 10; c++) begin
         excepttypeM = (c == 22) ? 32'h1 : 32'h0;
         if (c == 23) divE = 1'b0;
         @(negedge clk);
         exp = model_outputs(); got = dut_outs();
         n_checks++;
         if (got !== exp) begin
            n_fail++; $display("FAIL divexc_model c%0d: got %h want %h", c, got, exp);
         end
         if (div_done) done_seen++;
         tick();
      end
      n_checks++;
      if (done_seen != 0) begin
         n_fail++; $display("FAIL divexc_no_done: got %0d done cycles want 0", done_seen);
      end
   endtask

   task automatic test_async_reset();
      outs_t got, exp;
      idle_inputs();
      divE = 1'b1;
      for (int c = 0; c < 10; c++) tick();
      #2;
      rst = 1'b1;
      #1;
      m_elapsed = 0;
      n_checks++;
      if (div_start !== 1'b0 || div_done !== 1'b0) begin
         n_fail++; $display("FAIL async_rst_div: got %b%b want 00", div_start, div_done);
      end
      divE = 1'b0;
      #1;
      n_checks++;
      if (stallE !== 1'b0 || flushM !== 1'b0) begin
         n_fail++; $display("FAIL async_rst_idle: got stallE=%b flushM=%b want 0 0", stallE, flushM);
      end
      tick();
      rst = 1'b0;
      for (int c = 0; c < N + 4; c++) begin
         @(negedge clk);
         exp = model_outputs(); got = dut_outs();
         n_checks++;
         if (got !== exp || div_done !== 1'b0) begin
            n_fail++; $display("FAIL async_rst_after c%0d: got %h want %h", c, got, exp);
         end
         tick();
      end
   endtask

   task automatic test_random();
      outs_t got, exp;
      for (int c = 0; c < 1500; c++) begin
         rsD = 5'($urandom_range(0, 3)); rtD = 5'($urandom_range(0, 3));
         rsE = 5'($urandom_range(0, 3)); rtE = 5'($urandom_range(0, 3));
         writeregE = 5'($urandom_range(0, 3));
         writeregM = 5'($urandom_range(0, 3));
         writeregW = 5'($urandom_range(0, 3));
         regwriteE = 1'($urandom); regwriteM = 1'($urandom); regwriteW = 1'($urandom);
         memtoregE = ($urandom_range(0, 3) == 0);
         memtoregM = ($urandom_range(0, 3) == 0);
         branchD   = ($urandom_range(0, 3) == 0);
         jrD       = ($urandom_range(0, 7) == 0);
         divE      = ($urandom_range(0, 7) == 0);
         i_stall   = ($urandom_range(0, 5) == 0);
         d_stall   = ($urandom_range(0, 5) == 0);
         excepttypeM = ($urandom_range(0, 63) == 0) ? (32'h1 << $urandom_range(0, 31)) : 32'h0;
         @(negedge clk);
         exp = model_outputs(); got = dut_outs();
         n_checks++;
         if (got !== exp) begin
            n_fail++; $display("FAIL random c%0d: got %h want %h", c, got, exp);
         end
         tick();
      end
   endtask

   initial begin
      test_reset();
      test_lwstall();
      test_branch_and_zero();
      test_div();
      test_div_done_hold();
      test_memstall_except();
      test_div_except();
      test_async_reset();
      test_random();
      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule

// File: doc/hazard_unit.md
Name: hazard_unit

Overview:
- Pipeline hazard and stall/flush generator for the 5-stage MIPS core.
- Consumes the per-stage control/register info that the decode controller pipelines forward.
- Produces the stall*/flush* inputs that the controller and datapath pipeline registers consume, plus forwarding selects.
- Contains a multi-cycle divide sequencer and memory-wait handling. Exceptions resolved in M flush D/E/M.

Parameters:
DIV_CYCLES, 32, cycles the iterative divider needs after the start pulse (minimum 2)

Ports:
clk  input  1  clock, all state on rising edge
rst  input  1  reset, asynchronous, active-high
rsD, rtD  input  5  source regs in D
rsE, rtE  input  5  source regs in E
writeregE, writeregM, writeregW  input  5  destination reg per stage
regwriteE, regwriteM, regwriteW  input  1  reg write enable per stage
memtoregE, memtoregM  input  1  load in E / M
branchD, jrD  input  1  D-stage branch or jr (operands compared/used in D)
divE  input  1  div/divu in E
i_stall  input  1  instruction fetch not yet returned
d_stall  input  1  data access in M not yet returned
excepttypeM  input  32  nonzero = exception taken by M-stage instruction
forwardAD, forwardBD  output  1  D operand from M ALU result
forwardAE, forwardBE  output  2  00 regfile, 01 from W, 10 from M
stallF, stallD, stallE, stallM, stallW  output  1  hold pipeline register
flushD, flushE, flushM, flushW  output  1  bubble pipeline register
div_start  output  1  one-cycle pulse to start divider
div_done  output  1  divider result valid, HI/LO write allowed this cycle

Behaviour:
- Reset: div FSM = IDLE, counter = 0, div_start = 0, div_done = 0. All stall/flush outputs 0 whenever inputs are idle.
- Register 0 is never a forwarding or hazard source: every match requires writereg != 0.
- forwardAE:
  - 10 if regwriteM & writeregM == rsE;
  - else 01 if regwriteW & writeregW == rsE;
  - else 00.
  - M has priority over W.
- forwardBE: same as forwardAE, using rtE.
- forwardAD = regwriteM & writeregM == rsD. forwardBD: same with rtD.
- lwstall = memtoregE & (writeregE == rsD | writeregE == rtD).
- branchstall = (branchD | jrD) & ((regwriteE & writeregE ∈ {rsD, rtD}) | (memtoregM & writeregM ∈ {rsD, rtD})).
- memstall = i_stall | d_stall.
- except = (excepttypeM != 0) & ~memstall. An exception is honoured only in a non-stalled cycle; M holds while stalled.
- Div FSM:
  - IDLE: if divE & ~memstall & ~except → BUSY, counter = DIV_CYCLES-1, div_start = 1 for that cycle.
  - BUSY: counter decrements each cycle; counter == 0 → DONE. except → IDLE (the divide is abandoned).
  - DONE: div_done = 1; → IDLE when ~memstall, else stay in DONE. Never restarts from DONE, even though divE is still high.
  - divstall = (IDLE & divE & ~except) | BUSY.
- Stalls:
  - stallF = stallD = lwstall | branchstall | divstall | memstall.
  - stallE = divstall | memstall.
  - stallM = stallW = memstall.
  - All stalls forced 0 when except.
- Flushes:
  - flushE = ((lwstall | branchstall) & ~divstall & ~memstall) | except.
  - flushM = (divstall & ~memstall) | except.
  - flushD = except.
  - flushW = 0. The W instruction is older and commits.
- Simultaneous events:
  - memstall dominates: no flush is generated while memstall = 1, and the div FSM freezes in IDLE/DONE.
  - The BUSY countdown continues during memstall.
  - except dominates all other stall sources.
- Async reset mid-divide returns the FSM to IDLE with no div_done.
- Latency: a div occupies E for DIV_CYCLES+1 cycles (start cycle + DIV_CYCLES-1 busy + done) absent memstall.

Test Plan:
- lw $2 in E, add using $2 in D → stallF = stallD = 1 and flushE = 1 for exactly 1 cycle; next cycle forwardAE = 10 is not used (the load is in M); the one after, forwardAE = 01.
- add $3 in M, beq $3 in D → forwardAD = 1, no stall. add $3 in E, beq $3 in D → branchstall 1 cycle, flushE = 1.
- divE = 1, DIV_CYCLES = 32 → div_start pulses at cycle 0; stallE = 1 and flushM = 1 for 32 cycles; div_done = 1 at cycle 32 with stallE = 0; FSM back in IDLE at cycle 33.
- Writes to $0 in M and W with rsE = 0 → forwardAE = 00, no lwstall.
- d_stall = 1 for 3 cycles with excepttypeM = 0x4 → all stalls = 1 and no flush for 3 cycles; then flushD = flushE = flushM = 1 for 1 cycle with stalls = 0.
- Exception asserted while the div FSM is BUSY (counter = 10) → FSM returns to IDLE, div_done never asserts. Async rst during BUSY → IDLE immediately, div_start = div_done = 0.
